// File: rtl/sd_img_burst_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_img_burst_writer_if
//  Description : Pixel input, burst request and FIFO read bus of the
//                SD image burst writer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sd_img_burst_writer_if;
    logic [15:0]  pix_data;
    logic         pix_en;
    logic         wr_burst_req;
    logic [27:0]  wr_burst_addr;
    logic         wr_burst_ack;
    logic         wr_data_req;
    logic [127:0] wr_data;
    logic         frame_done;
    logic         overflow;

    // Writer side
    modport master (
        input  pix_data, pix_en, wr_burst_ack, wr_data_req,
        output wr_burst_req, wr_burst_addr, wr_data, frame_done, overflow
    );

    // Pixel source / memory controller side
    modport slave (
        output pix_data, pix_en, wr_burst_ack, wr_data_req,
        input  wr_burst_req, wr_burst_addr, wr_data, frame_done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/sd_img_burst_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_img_burst_writer
//  Description : Packs 16-bit pixels into 128-bit words, buffers them in a
//                FWFT FIFO and issues fixed-length write bursts that walk a
//                frame buffer, wrapping to BASE_ADDR at each frame end.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_img_burst_writer #(
    parameter int          H_VALID    = 1024,
    parameter int          V_VALID    = 768,
    parameter int          BURST_LEN  = 16,
    parameter logic [27:0] BASE_ADDR  = 28'h0,
    parameter int          FIFO_DEPTH = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    sd_img_burst_writer_if.master  bus
);
    localparam int TOTAL_PIX = H_VALID * V_VALID;
    localparam int PIX_W     = $clog2(TOTAL_PIX);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = $clog2(FIFO_DEPTH + 1);
    localparam int BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BPF       = TOTAL_PIX / (8 * BURST_LEN);
    localparam int BPF_W     = (BPF > 1) ? $clog2(BPF) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(TOTAL_PIX - 1);
    localparam logic [CW-1:0]    CNT_BURST  = CW'(BURST_LEN);
    localparam logic [CW-1:0]    CNT_FULL   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0]    BEAT_LAST  = BW'(BURST_LEN - 1);
    localparam logic [BPF_W-1:0] BURST_LAST = BPF_W'(BPF - 1);
    localparam logic [27:0]      ADDR_STEP  = 28'(BURST_LEN * 16);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [PIX_W-1:0]   pix_cnt;
    logic [111:0]       pack_reg;
    logic               push_vld;
    logic [127:0]       push_word;

    logic [127:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic [CW-1:0]      count;
    logic               full;
    logic               push;
    logic               pop;

    logic [BW-1:0]      beat;
    logic [BPF_W-1:0]   burst_idx;
    logic               overflow_q;
    logic               frame_done_q;
    logic [27:0]        addr_q;

    assign full = (count == CNT_FULL);
    assign push = push_vld && !full;
    assign pop  = (state == DATA) && bus.wr_data_req && (count != '0);

    // Pixel packing: lanes 0..6 collect in pack_reg, lane 7 completes the word
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt   <= '0;
            pack_reg  <= '0;
            push_vld  <= 1'b0;
            push_word <= '0;
        end else begin
            push_vld <= 1'b0;
            if (bus.pix_en) begin
                pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
                if (pix_cnt[2:0] == 3'd7) begin
                    push_vld  <= 1'b1;
                    push_word <= {bus.pix_data, pack_reg};
                end else begin
                    pack_reg[{pix_cnt[2:0], 4'b0000} +: 16] <= bus.pix_data;
                end
            end
        end
    end

    // FIFO storage; contents are qualified by count, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy; a word arriving while full is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_vld && full) overflow_q <= 1'b1;
        end
    end

    // Burst FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Burst FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count >= CNT_BURST) state_nxt = REQ;
            REQ:     if (bus.wr_burst_ack) state_nxt = DATA;
            DATA:    if (pop && (beat == BEAT_LAST)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beat counting, burst address walk and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            beat         <= '0;
            burst_idx    <= '0;
            addr_q       <= BASE_ADDR;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if ((state == REQ) && bus.wr_burst_ack) begin
                beat <= '0;
            end else if (pop) begin
                if (beat == BEAT_LAST) begin
                    beat <= '0;
                    if (burst_idx == BURST_LAST) begin
                        burst_idx    <= '0;
                        addr_q       <= BASE_ADDR;
                        frame_done_q <= 1'b1;
                    end else begin
                        burst_idx <= burst_idx + 1'b1;
                        addr_q    <= addr_q + ADDR_STEP;
                    end
                end else begin
                    beat <= beat + 1'b1;
                end
            end
        end
    end

    assign bus.wr_burst_req  = (state == REQ);
    assign bus.wr_burst_addr = addr_q;
    assign bus.wr_data       = (count == '0) ? '0 : mem[rptr];
    assign bus.frame_done    = frame_done_q;
    assign bus.overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_img_burst_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_img_burst_writer
//  Description : Directed self-checking bench for sd_img_burst_writer with a
//                64x4 frame (two 16-word bursts per frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_img_burst_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sd_img_burst_writer_if bus ();

    sd_img_burst_writer #(
        .H_VALID    (64),
        .V_VALID    (4),
        .BURST_LEN  (16),
        .BASE_ADDR  (28'h0),
        .FIFO_DEPTH (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mkword(input logic [15:0] base);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = base + 16'(k);
        return w;
    endfunction

    task automatic send_pix(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.pix_en   = 1'b1;
            bus.pix_data = base + 16'(i);
            tick();
        end
        bus.pix_en   = 1'b0;
        bus.pix_data = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   bus.wr_burst_req,  1'b0);
        chk({tag, "_addr"},  bus.wr_burst_addr, 28'h0);
        chk({tag, "_fdone"}, bus.frame_done,    1'b0);
        chk({tag, "_ovf"},   bus.overflow,      1'b0);
        chk({tag, "_data"},  bus.wr_data,       128'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Wait for a request, acknowledge after ack_delay cycles, pop npop words
    task automatic do_burst(input logic [27:0] exp_addr, input int ack_delay,
                            input logic [15:0] pix_base, input int word_base, input int npop);
        int n = 0;
        while (!bus.wr_burst_req && n < 64) begin
            tick();
            n++;
        end
        chk("burst_req", bus.wr_burst_req, 1'b1);
        chk("burst_addr", bus.wr_burst_addr, exp_addr);
        repeat (ack_delay) tick();
        chk("req_held", bus.wr_burst_req, 1'b1);
        bus.wr_burst_ack = 1'b1;
        tick();
        bus.wr_burst_ack = 1'b0;
        chk("req_drop", bus.wr_burst_req, 1'b0);
        bus.wr_data_req = 1'b1;
        for (int b = 0; b < npop; b++) begin
            if (b == 0 || b == npop - 1)
                chk("beat_data", bus.wr_data, mkword(pix_base + 16'((word_base + b) * 8)));
            tick();
        end
        bus.wr_data_req = 1'b0;
    endtask

    initial begin
        bus.pix_data     = '0;
        bus.pix_en       = 1'b0;
        bus.wr_burst_ack = 1'b0;
        bus.wr_data_req  = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("rst0");
        rst = 1'b0;

        // Single word packing
        send_pix(16'h0001, 8);
        tick();
        chk("pack_word", bus.wr_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("pack_noreq", bus.wr_burst_req, 1'b0);

        // One burst, ack after 3 cycles, continuous pops
        do_reset();
        send_pix(16'h0000, 128);
        tick();
        chk("b1_req_early", bus.wr_burst_req, 1'b0);
        tick();
        chk("b1_req_on", bus.wr_burst_req, 1'b1);
        do_burst(28'h0, 3, 16'h0000, 0, 16);
        chk("b1_idle_req", bus.wr_burst_req, 1'b0);
        chk("b1_next_addr", bus.wr_burst_addr, 28'h100);
        chk("b1_empty", bus.wr_data, 128'h0);
        chk("b1_fdone", bus.frame_done, 1'b0);

        // Full frame: two bursts and a frame_done pulse
        do_reset();
        send_pix(16'h0000, 256);
        do_burst(28'h0, 0, 16'h0000, 0, 16);
        chk("f_fdone_b1", bus.frame_done, 1'b0);
        do_burst(28'h100, 0, 16'h0000, 16, 16);
        chk("f_fdone_pulse", bus.frame_done, 1'b1);
        chk("f_addr_wrap", bus.wr_burst_addr, 28'h0);
        tick();
        chk("f_fdone_low", bus.frame_done, 1'b0);

        // Overflow: 64 words fill the FIFO, the 65th is dropped
        do_reset();
        send_pix(16'h0000, 512);
        tick();
        chk("ov_before", bus.overflow, 1'b0);
        chk("ov_req", bus.wr_burst_req, 1'b1);
        send_pix(16'h0200, 8);
        tick();
        chk("ov_set", bus.overflow, 1'b1);
        do_burst(28'h0,   0, 16'h0000, 0,  16);
        do_burst(28'h100, 0, 16'h0000, 16, 16);
        do_burst(28'h0,   0, 16'h0000, 32, 16);
        do_burst(28'h100, 0, 16'h0000, 48, 16);
        chk("ov_sticky", bus.overflow, 1'b1);
        chk("ov_drained", bus.wr_data, 128'h0);
        tick();
        chk("ov_no_req", bus.wr_burst_req, 1'b0);

        // Reset in the middle of a burst, with a partial word pending
        do_reset();
        send_pix(16'h0000, 131);
        do_burst(28'h0, 0, 16'h0000, 0, 5);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid");
        rst = 1'b0;
        send_pix(16'h0100, 128);
        do_burst(28'h0, 0, 16'h0100, 0, 16);
        chk("mid_next_addr", bus.wr_burst_addr, 28'h100);

        // Data request and ack while idle have no effect
        do_reset();
        send_pix(16'h0000, 8);
        tick();
        bus.wr_data_req  = 1'b1;
        bus.wr_burst_ack = 1'b1;
        tick();
        tick();
        tick();
        chk("idle_req", bus.wr_burst_req, 1'b0);
        chk("idle_nopop", bus.wr_data, mkword(16'h0000));
        bus.wr_data_req  = 1'b0;
        bus.wr_burst_ack = 1'b0;
        send_pix(16'h0008, 120);
        do_burst(28'h0, 0, 16'h0000, 0, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sd_img_burst_writer.md
SD_IMG_BURST_WRITER -- requirements
Module: sd_img_burst_writer

Interface
REQ-001 SHALL have parameter H_VALID, default 1024, active pixels per line.
REQ-002 SHALL have parameter V_VALID, default 768, active lines per frame.
REQ-003 SHALL have parameter BURST_LEN, default 16, 128-bit words per write burst.
REQ-004 SHALL have parameter BASE_ADDR, default 28'h0, byte address of frame buffer start.
REQ-005 SHALL have parameter FIFO_DEPTH, default 64, word FIFO depth (power of two, >= 2*BURST_LEN).
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port pix_data  input  16  pixel from SD reader, valid with pix_en.
REQ-009 SHALL have port pix_en  input  1  one pixel accepted per high cycle, no backpressure.
REQ-010 SHALL have port wr_burst_req  output  1  burst request, held until acknowledged.
REQ-011 SHALL have port wr_burst_addr  output  28  burst start byte address, stable while wr_burst_req high.
REQ-012 SHALL have port wr_burst_ack  input  1  one-cycle acknowledge of wr_burst_req.
REQ-013 SHALL have port wr_data_req  input  1  consumer pops one word this cycle.
REQ-014 SHALL have port wr_data  output  128  FIFO head word (first-word-fall-through).
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse, last burst of a frame popped.
REQ-016 SHALL have port overflow  output  1  sticky, a packed word was dropped.

Function
REQ-017 SHALL pack 8 consecutive accepted pixels into one word, first pixel in wr_data[15:0], eighth in [127:112].
REQ-018 SHALL write the packed word into the FIFO on the cycle after the 8th pixel's pix_en.
REQ-019 SHALL count pixels per frame; after H_VALID*V_VALID pixels the pixel counter wraps to 0 and the next pixel starts a new frame.
REQ-020 SHALL require H_VALID*V_VALID divisible by 8*BURST_LEN; other values are unsupported.
REQ-021 SHALL, when the FIFO is full at a word write, drop that word, set overflow, and keep the pixel/frame counters advancing.
REQ-022 SHALL hold overflow high until rst.
REQ-023 SHALL implement FSM IDLE, REQ, DATA.
REQ-024 SHALL move IDLE->REQ when FIFO occupancy >= BURST_LEN.
REQ-025 SHALL drive wr_burst_req high exactly in REQ; REQ->DATA on wr_burst_ack, beat counter cleared.
REQ-026 SHALL, in DATA, pop one word per cycle with wr_data_req high; after BURST_LEN pops return to IDLE.
REQ-027 SHALL ignore wr_data_req outside DATA or when the FIFO is empty (no pop, no count change).
REQ-028 SHALL handle a push and a pop in the same cycle with occupancy unchanged.
REQ-029 SHALL advance wr_burst_addr by BURST_LEN*16 bytes on each burst completion.
REQ-030 SHALL, on completion of the burst containing the frame's last word, reload wr_burst_addr to BASE_ADDR and pulse frame_done for one cycle.
REQ-031 SHALL treat wr_burst_ack outside REQ as having no effect.

Reset
REQ-032 SHALL, on rst high at any clock edge, including mid-burst, clear FIFO, pack register, pixel counter, beat counter, FSM to IDLE, wr_burst_addr=BASE_ADDR, wr_burst_req=0, frame_done=0, overflow=0, wr_data=0.
REQ-033 SHALL discard any partial word and partial burst on reset; the next pixel after reset is pixel 0 of a new frame.

Verification
REQ-034 SHALL test: pixels 0x0001..0x0008 on 8 consecutive cycles -> one FIFO word 0x0008_0007_0006_0005_0004_0003_0002_0001.
REQ-035 SHALL test: 128 pixels, ack in 3 cycles, wr_data_req continuous -> wr_burst_req after occupancy reaches 16, addr 0x0, 16 pops, FSM back to IDLE, next addr 0x100.
REQ-036 SHALL test: H_VALID=64, V_VALID=4 (256 pixels) -> two bursts at 0x0 and 0x100, frame_done pulses once after second burst's 16th pop, next burst addr 0x0.
REQ-037 SHALL test: wr_data_req held low with continuous pixels -> after 64 words FIFO full, next word dropped, overflow=1 and stays 1 after draining.
REQ-038 SHALL test: rst asserted after 5 pops of a burst -> all outputs at reset values next cycle, subsequent 128 pixels produce a burst at BASE_ADDR.
REQ-039 SHALL test: wr_data_req asserted in IDLE and wr_burst_ack asserted in IDLE -> no pop, no state change.
